debounce_scan_ctrl: RTL and testbench
=====================================

Name: debounce_scan_ctrl

Overview:
Multi-channel input-conditioning controller that time-shares one agree-filter datapath across N_CH asynchronous inputs such as buttons and switches. A prescaler generates a sample tick. On each tick an FSM scans the channels round-robin, shifting one sample per channel into a per-channel history register. A channel's filtered level changes only when all DEPTH history samples agree. Each level change is queued as an event behind a valid/ready interface for the downstream consumer (CPU register block or LED logic).

Parameters:
N_CH, 4, number of input channels (2..16)
DEPTH, 2, consecutive agreeing samples required to change level (2..6)
DIV, 50000, clk cycles per sample tick; must be > N_CH+1
CNT_W, 16, prescaler width; 2**CNT_W >= DIV
CH_W, 2, channel index width = clog2(N_CH)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
en  in  1  prescaler enable
in  in  N_CH  raw asynchronous inputs
filt  out  N_CH  filtered levels
evt_valid  out  1  event available at FIFO head
evt_ready  in  1  consumer accepts head event
evt_ch  out  CH_W  channel of head event
evt_level  out  1  new level of head event
ovf_clr  in  1  clears the ovf flag
ovf  out  1  sticky flag: event dropped because the FIFO was full
busy  out  1  high while the FSM is in SCAN

Behaviour:
- Reset (rst_n=0 at posedge) values:
  - filt=0, all histories=0, sync flops=0
  - prescaler=0, FSM=IDLE, FIFO empty
  - evt_valid=0, evt_ch=0, evt_level=0, ovf=0, busy=0
- Reset mid-scan or with events queued discards everything and takes priority over all other inputs.
- Synchronizer: each in bit passes through 2 flops (in_s) before any use.
- Prescaler:
  - While en=1: counts 0..DIV-1 and wraps; tick=1 in the cycle count==DIV-1.
  - While en=0: count forced to 0, no ticks.
  - Dropping en mid-scan does not abort the scan in progress.
- FSM IDLE:
  - On tick: idx<=0, go to SCAN.
- FSM SCAN (busy=1), one channel per cycle:
  - hist[idx] <= {hist[idx][DEPTH-2:0], in_s[idx]}.
  - If the new history is all-ones or all-zeros and its value differs from filt[idx]: filt[idx] updates at the same edge and an event {idx, new level} is pushed.
  - idx==N_CH-1: return to IDLE; otherwise idx+1.
  - Scan length is exactly N_CH cycles.
- Timing: with the tick at cycle T, channel i is sampled and filt[i] is updated at the posedge ending cycle T+1+i.
- Event FIFO:
  - 4 entries, show-ahead.
  - evt_valid rises the cycle after the first push into an empty FIFO.
  - A pop occurs on any cycle with evt_valid && evt_ready; the head advances on that edge.
  - Push while full with no pop in the same cycle: event dropped, ovf<=1, filt still updates.
  - Push while full with a same-cycle pop: push accepted, no overflow.
  - Push and pop while not full: occupancy unchanged.
  - Pop while empty: ignored.
- ovf: set has priority over ovf_clr in the same cycle.
- Worst-case latency from an in edge to filt: 2 sync cycles + DEPTH ticks + N_CH cycles.
- A single-sample glitch never changes filt when DEPTH>=2.

Test Plan:
All scenarios use N_CH=4, DEPTH=2, DIV=8.
1. Reset: hold rst_n=0 for 3 cycles with in=4'hF -> filt=0, evt_valid=0, ovf=0, busy=0; after release, busy first rises on the first tick 8 cycles later.
2. Steady press: in[2]=1 held -> filt[2]=1 on the 2nd tick's scan, at tick+3 cycles; one event (ch=2, level=1); no other channel changes.
3. Glitch rejection: in[1] pulses high for exactly one sample window -> filt[1] stays 0, no event.
4. Backpressure and overflow: evt_ready=0 while 5 channel transitions occur (press ch0..3, then release ch0) -> 4 events queued in order ch0, ch1, ch2, ch3; ovf=1; filt[0]=0. Then assert evt_ready -> 4 pops in 4 cycles, evt_valid falls. Pulse ovf_clr -> ovf=0.
5. Simultaneous push and pop at full: FIFO full, evt_ready=1 in the same cycle as a new event -> ovf stays 0, occupancy stays 4.
6. en dropped mid-scan: deassert en at tick+1 -> scan completes all 4 channels, prescaler stays 0, no further ticks until en=1.

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel debounce: one shared agree-filter scanned round-robin on each
// prescaler tick, with level-change events queued in a 4-deep show-ahead FIFO.
module debounce_scan_ctrl #(
    parameter int N_CH  = 4,
    parameter int DEPTH = 2,
    parameter int DIV   = 50000,
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] filt,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_level,
    input  logic            ovf_clr,
    output logic            ovf,
    output logic            busy
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nx;
    logic [CH_W-1:0]    idx, idx_nx;
    logic [N_CH-1:0]    in_m, in_s;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [DEPTH-1:0]   hist [N_CH];
    logic [DEPTH-1:0]   hist_new;
    logic               agree, push;
    logic [CH_W:0]      mem [4];
    logic [1:0]         wr_ptr, rd_ptr;
    logic [2:0]         count;
    logic               full, pop, wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_m <= '0;
            in_s <= '0;
            cnt  <= '0;
        end else begin
            in_m <= in;
            in_s <= in_m;
            if (!en || tick) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        busy     = (state == SCAN);
        case (state)
            IDLE: if (tick) begin
                state_nx = SCAN;
                idx_nx   = '0;
            end
            SCAN: begin
                if (idx == CH_W'(N_CH - 1)) state_nx = IDLE;
                else                        idx_nx   = idx + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The level only moves once every sample in the window agrees.
    always_comb begin
        hist_new = {hist[idx][DEPTH-2:0], in_s[idx]};
        agree    = (&hist_new) | ~(|hist_new);
        push     = busy && agree && (hist_new[0] != filt[idx]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < N_CH; i++) hist[i] <= '0;
        end else if (busy) begin
            hist[idx] <= hist_new;
            if (push) filt[idx] <= hist_new[0];
        end
    end

    assign full      = (count == 3'd4);
    assign evt_valid = (count != 3'd0);
    assign pop       = evt_valid && evt_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO survives.
    assign wr_en     = push && (!full || pop);
    assign {evt_ch, evt_level} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {idx, hist_new[0]};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (push && full && !pop) ovf <= 1'b1;
            else if (ovf_clr)         ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl (N_CH=4, DEPTH=2, DIV=8) with an
// event scoreboard checked whenever the consumer pops.
module tb_debounce_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, en, evt_ready, ovf_clr;
    logic [3:0] in, filt;
    logic       evt_valid, evt_level, ovf, busy;
    logic [1:0] evt_ch;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    debounce_scan_ctrl #(.N_CH(4), .DEPTH(2), .DIV(8), .CNT_W(16), .CH_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in), .filt(filt),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_level(evt_level), .ovf_clr(ovf_clr), .ovf(ovf), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted pop must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL evt_unexpected: got ch%0d lvl%0d expected none", evt_ch, evt_level);
            end else begin
                check("evt", {29'd0, evt_ch, evt_level}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_busy(input logic lvl);
        bit hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            hit = (busy === lvl);
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $error("FAIL busy_timeout: got %b expected %b", busy, lvl);
        end
    endtask

    task automatic wait_rise(); wait_busy(1'b0); wait_busy(1'b1); endtask
    task automatic wait_end();  wait_busy(1'b1); wait_busy(1'b0); endtask

    // Called just after the prescaler restarts from 0: busy must show on the 9th negedge.
    task automatic check_tick_delay(input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen |= busy;
        end
        check({tag, "_early"}, {31'd0, seen}, 32'd0);
        @(negedge clk);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic drain4(input string tag);
        @(posedge clk); #1 evt_ready = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, "_valid_last"}, {31'd0, evt_valid}, 32'd1);
        @(negedge clk);
        check({tag, "_valid_fall"}, {31'd0, evt_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n = 1'b0; en = 1'b1; in = 4'hF; evt_ready = 1'b1; ovf_clr = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_filt",  {28'd0, filt}, 32'd0);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_ovf",   {31'd0, ovf}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_evt",   {29'd0, evt_ch, evt_level}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; in = 4'h0;
        check_tick_delay("rst_tick");

        // Steady press on ch2, exact update cycle
        wait_end();
        in = 4'b0100;
        exp_q.push_back({2'd2, 1'b1});
        wait_rise(); wait_end(); wait_rise();
        repeat (2) @(negedge clk);
        check("press_before", {28'd0, filt}, 32'h0);
        @(negedge clk);
        check("press_after", {28'd0, filt}, 32'h4);
        wait_end();

        // Single-window glitch on ch1
        in = 4'b0110;
        wait_end();
        in = 4'b0100;
        wait_end(); wait_end();
        check("glitch_filt",  {28'd0, filt}, 32'h4);
        check("glitch_valid", {31'd0, evt_valid}, 32'd0);

        in = 4'b0000;
        exp_q.push_back({2'd2, 1'b0});
        wait_end(); wait_end();
        @(negedge clk);
        check("release_filt", {28'd0, filt}, 32'h0);

        // Backpressure and overflow
        @(posedge clk); #1 evt_ready = 1'b0;
        wait_end();
        in = 4'hF;
        for (int c = 0; c < 4; c++) exp_q.push_back({c[1:0], 1'b1});
        wait_end(); wait_end();
        in = 4'hE;
        wait_end(); wait_end();
        check("ovf_set",   {31'd0, ovf}, 32'd1);
        check("ovf_filt",  {28'd0, filt}, 32'hE);
        check("ovf_valid", {31'd0, evt_valid}, 32'd1);
        drain4("ovf_drain");
        check("ovf_hold", {31'd0, ovf}, 32'd1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", {31'd0, ovf}, 32'd0);

        // Push and pop on the same edge while full
        @(posedge clk); #1 evt_ready = 1'b0;
        wait_end();
        in = 4'b0001;
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd1, 1'b0});
        exp_q.push_back({2'd2, 1'b0});
        exp_q.push_back({2'd3, 1'b0});
        wait_end(); wait_end();
        in = 4'b1001;
        exp_q.push_back({2'd3, 1'b1});
        wait_rise(); wait_end(); wait_rise();
        repeat (3) @(posedge clk);
        #1 evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
        @(negedge clk);
        check("full_pp_ovf",   {31'd0, ovf}, 32'd0);
        check("full_pp_valid", {31'd0, evt_valid}, 32'd1);
        check("full_pp_filt",  {28'd0, filt}, 32'h9);
        drain4("full_pp_drain");

        // en dropped one cycle into a scan
        wait_end();
        in = 4'b0000;
        exp_q.push_back({2'd0, 1'b0});
        exp_q.push_back({2'd3, 1'b0});
        wait_rise(); wait_end(); wait_rise();
        #1 en = 1'b0;
        seen = 1'b1;
        repeat (3) begin
            @(negedge clk);
            seen &= busy;
        end
        check("en_scan_busy", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("en_scan_done", {31'd0, busy}, 32'd0);
        check("en_scan_filt", {28'd0, filt}, 32'h0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= busy;
        end
        check("en_no_tick", {31'd0, seen}, 32'd0);
        @(posedge clk); #1 en = 1'b1;
        check_tick_delay("en_tick");

        repeat (10) @(negedge clk);
        check("sb_empty",    exp_q.size(), 32'd0);
        check("final_valid", {31'd0, evt_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
